// File: rtl/wb_port_arb.sv
// Regfile write-port arbiter: fixed priority to the pipe writeback (P) with a
// starvation counter that force-grants the long-latency unit (M). Outputs registered.
module wb_port_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            p_valid_i,
  output logic            p_ready_o,
  input  logic [4:0]      p_rd_i,
  input  logic [XLEN-1:0] p_wdata_i,
  input  logic            m_valid_i,
  output logic            m_ready_o,
  input  logic [4:0]      m_rd_i,
  input  logic [XLEN-1:0] m_wdata_i,
  output logic            rf_wen_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [1:0]      grant_o,
  output logic            p_stall_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic            p_gnt;
  logic            m_gnt;
  logic [3:0]      cnt_d,   cnt_q;
  logic            wen_d,   wen_q;
  logic [4:0]      rd_d,    rd_q;
  logic [XLEN-1:0] wdata_d, wdata_q;
  logic [1:0]      grant_d, grant_q;

  // Grant decision; M only wins contention once it has lost STARVE_MAX cycles in a row.
  always_comb begin
    p_gnt = 1'b0;
    m_gnt = 1'b0;
    if (p_valid_i && m_valid_i) begin
      if (cnt_q >= STARVE_LIM) begin
        m_gnt = 1'b1;
      end else begin
        p_gnt = 1'b1;
      end
    end else if (p_valid_i) begin
      p_gnt = 1'b1;
    end else if (m_valid_i) begin
      m_gnt = 1'b1;
    end else begin
      p_gnt = 1'b0;
      m_gnt = 1'b0;
    end
  end

  assign p_ready_o = p_gnt;
  assign m_ready_o = m_gnt;
  assign p_stall_o = p_valid_i & ~p_gnt;

  // Starvation counter; cleared whenever M is served or withdraws.
  always_comb begin
    cnt_d = cnt_q;
    if (!m_valid_i || m_gnt) begin
      cnt_d = 4'd0;
    end else if (cnt_q < STARVE_LIM) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next output register contents; index/data hold when nothing is granted.
  always_comb begin
    wen_d   = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    grant_d = 2'b00;
    if (p_gnt) begin
      wen_d   = (p_rd_i != 5'd0);
      rd_d    = p_rd_i;
      wdata_d = p_wdata_i;
      grant_d = 2'b01;
    end else if (m_gnt) begin
      wen_d   = (m_rd_i != 5'd0);
      rd_d    = m_rd_i;
      wdata_d = m_wdata_i;
      grant_d = 2'b10;
    end else begin
      wen_d   = 1'b0;
      grant_d = 2'b00;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      rd_q    <= 5'd0;
      wdata_q <= {XLEN{1'b0}};
      grant_q <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
    end
  end

  assign rf_wen_o   = wen_q;
  assign rf_rd_o    = rd_q;
  assign rf_wdata_o = wdata_q;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed self-checking bench for wb_port_arb with hand-computed expectations.
module tb_wb_port_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        p_valid_i;
  logic        p_ready_o;
  logic [4:0]  p_rd_i;
  logic [31:0] p_wdata_i;
  logic        m_valid_i;
  logic        m_ready_o;
  logic [4:0]  m_rd_i;
  logic [31:0] m_wdata_i;
  logic        rf_wen_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;
  logic [1:0]  grant_o;
  logic        p_stall_o;

  int checks   = 0;
  int failures = 0;

  wb_port_arb #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .p_valid_i  (p_valid_i),
    .p_ready_o  (p_ready_o),
    .p_rd_i     (p_rd_i),
    .p_wdata_i  (p_wdata_i),
    .m_valid_i  (m_valid_i),
    .m_ready_o  (m_ready_o),
    .m_rd_i     (m_rd_i),
    .m_wdata_i  (m_wdata_i),
    .rf_wen_o   (rf_wen_o),
    .rf_rd_o    (rf_rd_o),
    .rf_wdata_o (rf_wdata_o),
    .grant_o    (grant_o),
    .p_stall_o  (p_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    p_valid_i = 1'b0; p_rd_i = 5'd0; p_wdata_i = 32'd0;
    m_valid_i = 1'b0; m_rd_i = 5'd0; m_wdata_i = 32'd0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_wen",   64'(rf_wen_o),   64'd0);
    chk("rst_grant", 64'(grant_o),    64'd0);
    chk("rst_rd",    64'(rf_rd_o),    64'd0);
    chk("rst_wdata", 64'(rf_wdata_o), 64'd0);
    chk("rst_cnt",   64'(dut.cnt_q),  64'd0);
    cyc();

    // P only
    p_valid_i = 1'b1; p_rd_i = 5'd5; p_wdata_i = 32'hDEADBEEF;
    #1;
    chk("p_only_pready", 64'(p_ready_o), 64'd1);
    chk("p_only_mready", 64'(m_ready_o), 64'd0);
    chk("p_only_stall",  64'(p_stall_o), 64'd0);
    cyc();
    p_valid_i = 1'b0;
    chk("p_only_wen",   64'(rf_wen_o),   64'd1);
    chk("p_only_rd",    64'(rf_rd_o),    64'd5);
    chk("p_only_wdata", 64'(rf_wdata_o), 64'hDEADBEEF);
    chk("p_only_grant", 64'(grant_o),    64'd1);

    // Idle gap: index/data hold
    #1;
    chk("idle_pready", 64'(p_ready_o), 64'd0);
    chk("idle_mready", 64'(m_ready_o), 64'd0);
    cyc();
    chk("idle_wen",   64'(rf_wen_o),   64'd0);
    chk("idle_grant", 64'(grant_o),    64'd0);
    chk("idle_rd",    64'(rf_rd_o),    64'd5);
    chk("idle_wdata", 64'(rf_wdata_o), 64'hDEADBEEF);

    // x0 write from M
    m_valid_i = 1'b1; m_rd_i = 5'd0; m_wdata_i = 32'hFFFFFFFF;
    #1;
    chk("x0_mready", 64'(m_ready_o), 64'd1);
    chk("x0_pready", 64'(p_ready_o), 64'd0);
    cyc();
    m_valid_i = 1'b0;
    chk("x0_wen",   64'(rf_wen_o),   64'd0);
    chk("x0_grant", 64'(grant_o),    64'd2);
    chk("x0_wdata", 64'(rf_wdata_o), 64'hFFFFFFFF);
    cyc();

    // Contention: P wins 4 cycles, then M is forced through
    m_valid_i = 1'b1; m_rd_i = 5'd7; m_wdata_i = 32'h12345678;
    p_valid_i = 1'b1; p_rd_i = 5'd3;
    for (int i = 0; i < 4; i++) begin
      p_wdata_i = 32'hA0 + 32'(i);
      #1;
      chk("cont_pready", 64'(p_ready_o), 64'd1);
      chk("cont_mready", 64'(m_ready_o), 64'd0);
      cyc();
      chk("cont_cnt",   64'(dut.cnt_q),  64'(i + 1));
      chk("cont_grant", 64'(grant_o),    64'd1);
      chk("cont_wdata", 64'(rf_wdata_o), 64'(32'hA0 + 32'(i)));
    end
    p_wdata_i = 32'hB0;
    #1;
    chk("force_mready", 64'(m_ready_o), 64'd1);
    chk("force_pready", 64'(p_ready_o), 64'd0);
    chk("force_stall",  64'(p_stall_o), 64'd1);
    cyc();
    chk("force_wen",   64'(rf_wen_o),   64'd1);
    chk("force_rd",    64'(rf_rd_o),    64'd7);
    chk("force_wdata", 64'(rf_wdata_o), 64'h12345678);
    chk("force_grant", 64'(grant_o),    64'd2);
    chk("force_cnt",   64'(dut.cnt_q),  64'd0);
    m_rd_i = 5'd8; m_wdata_i = 32'h55;
    #1;
    chk("after_pready", 64'(p_ready_o), 64'd1);
    chk("after_stall",  64'(p_stall_o), 64'd0);
    cyc();
    chk("after_grant", 64'(grant_o),    64'd1);
    chk("after_wdata", 64'(rf_wdata_o), 64'hB0);
    p_valid_i = 1'b0; m_valid_i = 1'b0;
    cyc();
    chk("drain_cnt", 64'(dut.cnt_q), 64'd0);

    // Counter clears when M drops for a cycle
    p_valid_i = 1'b1; m_valid_i = 1'b1;
    repeat (3) cyc();
    chk("clr_cnt3", 64'(dut.cnt_q), 64'd3);
    m_valid_i = 1'b0;
    cyc();
    chk("clr_cnt0", 64'(dut.cnt_q), 64'd0);
    m_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("clr_wait_mready", 64'(m_ready_o), 64'd0);
      cyc();
    end
    #1;
    chk("clr_grant_mready", 64'(m_ready_o), 64'd1);
    cyc();

    // Reset between edges while a write is live
    m_valid_i = 1'b1; p_valid_i = 1'b1; p_rd_i = 5'd9; p_wdata_i = 32'hCAFEF00D;
    cyc();
    chk("pre_rst_wen", 64'(rf_wen_o),  64'd1);
    chk("pre_rst_cnt", 64'(dut.cnt_q), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_wen",   64'(rf_wen_o),   64'd0);
    chk("mid_rst_grant", 64'(grant_o),    64'd0);
    chk("mid_rst_rd",    64'(rf_rd_o),    64'd0);
    chk("mid_rst_wdata", 64'(rf_wdata_o), 64'd0);
    chk("mid_rst_cnt",   64'(dut.cnt_q),  64'd0);
    p_valid_i = 1'b0; m_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc();
    chk("post_rst_cnt", 64'(dut.cnt_q), 64'd0);
    chk("post_rst_wen", 64'(rf_wen_o),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
